// File: rtl/frotaegis_pkg.sv
// -----------------------------------------------------------------------------
// frotaegis_pkg
// Shared definitions for the frame-readout to AXI-Stream bridge:
//   - bridge_state_e : framing FSM states (IDLE / PASS / DROP)
//   - AXIS_WIDTH     : S2MM stream data width
//   - AXIS_KEEP      : byte-keep value driven on every beat
//   - ENTRY_*_OFS    : positions of the flag bits that sit just above the
//                      sample data inside one FIFO entry
// -----------------------------------------------------------------------------
package frotaegis_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } bridge_state_e;

    localparam int         AXIS_WIDTH = 32;
    localparam logic [3:0] AXIS_KEEP  = 4'hF;

    // A FIFO entry is {natural, last, data}. The offsets are counted from
    // the first bit above the sample data.
    localparam int ENTRY_LAST_OFS    = 0;
    localparam int ENTRY_NATURAL_OFS = 1;

    // Absolute bit index of a flag inside an entry with the given sample width.
    function automatic int entry_bit(input int data_size, input int ofs);
        return data_size + ofs;
    endfunction

endpackage

// File: rtl/frotaegis_sync_fifo.sv
// -----------------------------------------------------------------------------
// frotaegis_sync_fifo
// Single-clock first-word-fall-through FIFO with a registered output stage.
// The head entry is copied into an output register, so rd_data/rd_valid come
// straight from flops. An entry stays counted until it leaves the output
// register, so count is the true number of entries held.
//
// Parameters: WIDTH (entry width), DEPTH (entries, power of 2),
//             ADDR (log2(DEPTH)).
// Ports:
//   clk       in   clock
//   rstn      in   synchronous reset, active-low
//   wr_en     in   write request; ignored while the FIFO is full
//   wr_data   in   WIDTH  entry to write
//   rd_data   out  WIDTH  head entry (valid when rd_valid=1)
//   rd_valid  out  head entry present in the output register
//   rd_ready  in   consumer accepts the head entry
//   count     out  ADDR+1 current occupancy
// -----------------------------------------------------------------------------
module frotaegis_sync_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 16,
    parameter int ADDR  = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [ADDR:0]    count
);

    localparam logic [ADDR:0]   FULL_COUNT = (ADDR + 1)'(DEPTH);
    localparam logic [ADDR:0]   ONE_COUNT  = (ADDR + 1)'(1);
    localparam logic [ADDR-1:0] PTR_ONE    = ADDR'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR:0]    count_q, count_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             do_write;
    logic             do_pop;

    // Pointer, occupancy and output-register update. rd_ptr always names the
    // entry that is (or is about to be) in the output register. On a pop the
    // next entry is loaded in the same cycle when one is already stored, which
    // gives one beat per cycle; an entry landing in an empty FIFO is moved
    // into the output register on the following edge.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        do_write = wr_en && (count_q < FULL_COUNT);
        do_pop   = out_valid_q && rd_ready;

        if (do_write) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (count_q > ONE_COUNT) begin
                out_data_d = mem_q[rd_ptr_d];
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (!out_valid_q && (count_q != '0)) begin
            out_data_d  = mem_q[rd_ptr_q];
            out_valid_d = 1'b1;
        end

        if (do_write && !do_pop) begin
            count_d = count_q + ONE_COUNT;
        end else if (!do_write && do_pop) begin
            count_d = count_q - ONE_COUNT;
        end
    end

    // Storage array; its contents are meaningless until counted, so it
    // needs no reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Control and output-stage registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign rd_data  = out_data_q;
    assign rd_valid = out_valid_q;
    assign count    = count_q;

endmodule

// File: rtl/fram_axis_bridge.sv
// -----------------------------------------------------------------------------
// fram_axis_bridge
// Buffers the frame readout stream (FramData/FramAdd/FramEn, no backpressure)
// in a FIFO and presents it as an AXI-Stream master for the S2MM DMA. Frames
// that do not fit are dropped whole, or cut short with a forced tlast, so the
// DMA never sees an unterminated packet.
//
// Optional feature: define FRAM_AXIS_DROPCNT_EN to build a 16-bit saturating
// discarded-sample counter on DropCnt; without it DropCnt is tied to 0.
//
// Ports:
//   clk            in   clock
//   rstn           in   synchronous reset, active-low
//   Enable         in   accept new frames
//   OvfClr         in   one-cycle pulse clearing Overflow (and DropCnt)
//   FramData       in   DATA_SIZE    sample
//   FramAdd        in   LENGTH_SIZE  sample index within the frame
//   FramEn         in   sample strobe
//   m_axis_tdata   out  32  zero-extended sample
//   m_axis_tkeep   out  4   constant all-ones
//   m_axis_tlast   out  last beat of a packet
//   m_axis_tvalid  out  beat valid
//   m_axis_tready  in   sink ready
//   Overflow       out  sticky: a sample was discarded
//   FrameCnt       out  16  packets sent with a natural tlast (wraps)
//   Level          out  FIFO_ADD+1  FIFO occupancy
//   DropCnt        out  16  discarded samples (optional)
// -----------------------------------------------------------------------------
module fram_axis_bridge
    import frotaegis_pkg::*;
#(
    parameter int DATA_SIZE   = 12,
    parameter int LENGTH      = 32768,
    parameter int LENGTH_SIZE = 15,
    parameter int FIFO_DEPTH  = 16,
    parameter int FIFO_ADD    = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   Enable,
    input  logic                   OvfClr,
    input  logic [DATA_SIZE-1:0]   FramData,
    input  logic [LENGTH_SIZE-1:0] FramAdd,
    input  logic                   FramEn,
    output logic [AXIS_WIDTH-1:0]  m_axis_tdata,
    output logic [3:0]             m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   Overflow,
    output logic [15:0]            FrameCnt,
    output logic [FIFO_ADD:0]      Level,
    output logic [15:0]            DropCnt
);

    localparam int ENTRY_W     = DATA_SIZE + 2;
    localparam int LAST_BIT    = entry_bit(DATA_SIZE, ENTRY_LAST_OFS);
    localparam int NATURAL_BIT = entry_bit(DATA_SIZE, ENTRY_NATURAL_OFS);

    localparam logic [LENGTH_SIZE-1:0] LAST_ADD      = LENGTH_SIZE'(LENGTH - 1);
    localparam logic [FIFO_ADD:0]      RESERVE_LEVEL = (FIFO_ADD + 1)'(FIFO_DEPTH - 1);

    bridge_state_e state_q, state_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic               wr_en;
    logic               wr_last;
    logic               wr_natural;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic               rd_valid;
    logic [FIFO_ADD:0]  fifo_count;
    logic               drop_sample;
    logic               ovf_event;
    logic               frame_start;
    logic               frame_end;
    logic               beat_xfer;

    frotaegis_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .ADDR  (FIFO_ADD)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (wr_en),
        .wr_data  (wr_entry),
        .rd_data  (rd_entry),
        .rd_valid (rd_valid),
        .rd_ready (m_axis_tready),
        .count    (fifo_count)
    );

    // Framing FSM. A frame is admitted only when at least two slots are free,
    // and while a frame is passing the last free slot is kept for a
    // terminator: if the FIFO reaches one-below-full mid-frame the current
    // sample is written with a forced tlast and the rest of the frame is
    // dropped. All decisions use the occupancy from before the edge.
    always_comb begin
        state_d     = state_q;
        wr_en       = 1'b0;
        wr_last     = 1'b0;
        wr_natural  = 1'b0;
        drop_sample = 1'b0;
        ovf_event   = 1'b0;

        frame_start = FramEn && (FramAdd == '0);
        frame_end   = FramEn && (FramAdd == LAST_ADD);

        case (state_q)
            IDLE: begin
                if (frame_start && Enable) begin
                    if (fifo_count < RESERVE_LEVEL) begin
                        wr_en   = 1'b1;
                        state_d = PASS;
                    end else begin
                        drop_sample = 1'b1;
                        ovf_event   = 1'b1;
                        state_d     = DROP;
                    end
                end
            end
            PASS: begin
                if (FramEn) begin
                    wr_en = 1'b1;
                    if (frame_end) begin
                        wr_last    = 1'b1;
                        wr_natural = 1'b1;
                        state_d    = IDLE;
                    end else if (fifo_count == RESERVE_LEVEL) begin
                        wr_last   = 1'b1;
                        ovf_event = 1'b1;
                        state_d   = DROP;
                    end
                end
            end
            DROP: begin
                if (FramEn) begin
                    drop_sample = 1'b1;
                    if (frame_end) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Entry packing: the natural flag travels with the data so the packet
    // counter can tell a real frame end from a forced one at transfer time.
    always_comb begin
        wr_entry                  = '0;
        wr_entry[DATA_SIZE-1:0]   = FramData;
        wr_entry[LAST_BIT]        = wr_last;
        wr_entry[NATURAL_BIT]     = wr_natural;
    end

    // Sticky overflow (a new overflow beats a coincident clear) and the
    // count of naturally terminated packets actually handed to the sink.
    always_comb begin
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;
        beat_xfer   = rd_valid && m_axis_tready;

        if (ovf_event) begin
            overflow_d = 1'b1;
        end else if (OvfClr) begin
            overflow_d = 1'b0;
        end

        if (beat_xfer && rd_entry[LAST_BIT] && rd_entry[NATURAL_BIT]) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // State and status registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef FRAM_AXIS_DROPCNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating discarded-sample counter. A clear and a discard in the same
    // cycle leave a count of one, so the new discard is not lost.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (OvfClr) begin
            drop_cnt_d = '0;
        end
        if (drop_sample && (drop_cnt_d != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_d + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign DropCnt = drop_cnt_q;
`else
    logic unused_drop_sample;
    assign unused_drop_sample = drop_sample;
    assign DropCnt            = '0;
`endif

    assign m_axis_tdata  = AXIS_WIDTH'(rd_entry[DATA_SIZE-1:0]);
    assign m_axis_tkeep  = AXIS_KEEP;
    assign m_axis_tlast  = rd_entry[LAST_BIT];
    assign m_axis_tvalid = rd_valid;
    assign Overflow      = overflow_q;
    assign FrameCnt      = frame_cnt_q;
    assign Level         = fifo_count;

endmodule

// File: tb/tb_fram_axis_bridge.sv
// -----------------------------------------------------------------------------
// tb_fram_axis_bridge
// Self-checking bench for fram_axis_bridge with LENGTH=16, FIFO_DEPTH=16.
// A reference model keeps the expected FIFO contents as a queue of
// {data, last, natural} records and applies the framing rules to it every
// cycle; directed sequences add hand-computed expectations for the corner
// cases, followed by a randomized run against the same model.
// Honours FRAM_AXIS_DROPCNT_EN for the DropCnt expectation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fram_axis_bridge;

    localparam int DATA_SIZE   = 12;
    localparam int LENGTH      = 16;
    localparam int LENGTH_SIZE = 4;
    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_ADD    = 4;

`ifdef FRAM_AXIS_DROPCNT_EN
    localparam bit DROPCNT_ON = 1'b1;
`else
    localparam bit DROPCNT_ON = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   Enable;
    logic                   OvfClr;
    logic [DATA_SIZE-1:0]   FramData;
    logic [LENGTH_SIZE-1:0] FramAdd;
    logic                   FramEn;
    logic [31:0]            m_axis_tdata;
    logic [3:0]             m_axis_tkeep;
    logic                   m_axis_tlast;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;
    logic                   Overflow;
    logic [15:0]            FrameCnt;
    logic [FIFO_ADD:0]      Level;
    logic [15:0]            DropCnt;

    always #5 clk = ~clk;

    fram_axis_bridge #(
        .DATA_SIZE   (DATA_SIZE),
        .LENGTH      (LENGTH),
        .LENGTH_SIZE (LENGTH_SIZE),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .FIFO_ADD    (FIFO_ADD)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .Enable        (Enable),
        .OvfClr        (OvfClr),
        .FramData      (FramData),
        .FramAdd       (FramAdd),
        .FramEn        (FramEn),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .Overflow      (Overflow),
        .FrameCnt      (FrameCnt),
        .Level         (Level),
        .DropCnt       (DropCnt)
    );

    typedef struct {
        logic [11:0] data;
        bit          last;
        bit          natural;
    } entry_t;

    typedef struct {
        logic [31:0] data;
        bit          last;
    } beat_t;

    typedef struct {
        logic [3:0]  add;
        logic [11:0] data;
        logic [31:0] exp_tdata;
        bit          exp_tlast;
    } vec_t;

    // Reference model state
    entry_t      model_q[$];
    bit          m_in_frame;
    bit          m_skipping;
    bit          m_ovf;
    logic [15:0] m_frames;
    int          m_drops;

    beat_t beat_log[$];
    int    n_compared   = 0;
    int    n_mismatched = 0;
    int    level_max    = 0;
    int    stall_run    = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs, lets the edge happen, advances the model by
    // the spec rules and compares every observable output.
    task automatic applyStimulus(input bit r, input bit en, input bit clr, input bit fen,
                                 input logic [3:0] add, input logic [11:0] data, input bit rdy);
        logic        pre_valid;
        logic        pre_last;
        logic [31:0] pre_data;
        int          sz;
        bit          ovf_evt;
        bit          drop_evt;
        entry_t      e;

        rstn          = r;
        Enable        = en;
        OvfClr        = clr;
        FramEn        = fen;
        FramAdd       = add;
        FramData      = data;
        m_axis_tready = rdy;
        pre_valid     = m_axis_tvalid;
        pre_last      = m_axis_tlast;
        pre_data      = m_axis_tdata;

        @(posedge clk);
        #1;

        if (!r) begin
            model_q.delete();
            m_in_frame = 0;
            m_skipping = 0;
            m_ovf      = 0;
            m_frames   = '0;
            m_drops    = 0;
        end else begin
            sz       = model_q.size();
            ovf_evt  = 0;
            drop_evt = 0;
            if (pre_valid && rdy) begin
                beat_log.push_back('{pre_data, pre_last});
                if (sz == 0) begin
                    checkOutput("phantom_beat", 32'(pre_valid), 32'd0);
                end else begin
                    e = model_q.pop_front();
                    checkOutput("beat_data", pre_data, {20'd0, e.data});
                    checkOutput("beat_last", 32'(pre_last), 32'(e.last));
                    if (e.last && e.natural) m_frames = m_frames + 16'd1;
                end
            end
            if (fen) begin
                if (m_skipping) begin
                    drop_evt = 1;
                    if (int'(add) == LENGTH - 1) m_skipping = 0;
                end else if (m_in_frame) begin
                    if (int'(add) == LENGTH - 1) begin
                        model_q.push_back('{data, 1'b1, 1'b1});
                        m_in_frame = 0;
                    end else if (sz == FIFO_DEPTH - 1) begin
                        model_q.push_back('{data, 1'b1, 1'b0});
                        ovf_evt    = 1;
                        m_in_frame = 0;
                        m_skipping = 1;
                    end else begin
                        model_q.push_back('{data, 1'b0, 1'b0});
                    end
                end else if (add == 4'd0 && en) begin
                    if (sz < FIFO_DEPTH - 1) begin
                        model_q.push_back('{data, 1'b0, 1'b0});
                        m_in_frame = 1;
                    end else begin
                        ovf_evt    = 1;
                        drop_evt   = 1;
                        m_skipping = 1;
                    end
                end
            end
            if (ovf_evt) m_ovf = 1;
            else if (clr) m_ovf = 0;
            if (clr) m_drops = 0;
            if (drop_evt && m_drops < 65535) m_drops++;
        end

        checkOutput("level", 32'(Level), 32'(model_q.size()));
        checkOutput("overflow", 32'(Overflow), 32'(m_ovf));
        checkOutput("frame_cnt", 32'(FrameCnt), 32'(m_frames));
        checkOutput("drop_cnt", 32'(DropCnt), DROPCNT_ON ? 32'(m_drops) : 32'd0);
        checkOutput("tkeep", 32'(m_axis_tkeep), 32'hF);
        if (!r) begin
            checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
            checkOutput("rst_tlast", 32'(m_axis_tlast), 32'd0);
            checkOutput("rst_tdata", m_axis_tdata, 32'd0);
        end else begin
            if (m_axis_tvalid) begin
                if (model_q.size() == 0) begin
                    checkOutput("phantom_valid", 32'(m_axis_tvalid), 32'd0);
                end else begin
                    checkOutput("head_data", m_axis_tdata, {20'd0, model_q[0].data});
                    checkOutput("head_last", 32'(m_axis_tlast), 32'(model_q[0].last));
                end
            end
            if (pre_valid && !rdy) begin
                checkOutput("hold_valid", 32'(m_axis_tvalid), 32'd1);
                checkOutput("hold_data", m_axis_tdata, pre_data);
                checkOutput("hold_last", 32'(m_axis_tlast), 32'(pre_last));
            end
        end
        if (model_q.size() > 0 && !m_axis_tvalid) stall_run++;
        else stall_run = 0;
        checkOutput("valid_latency", 32'(stall_run > 1), 32'd0);
        if (int'(Level) > level_max) level_max = int'(Level);
    endtask

    task automatic idleCycle(input bit clr, input bit rdy);
        applyStimulus(1'b1, 1'b1, clr, 1'b0, 4'd0, 12'd0, rdy);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((model_q.size() != 0 || m_axis_tvalid) && guard < 64) begin
            idleCycle(1'b0, 1'b1);
            guard++;
        end
        checkOutput("drain_empty", 32'(model_q.size()), 32'd0);
        checkOutput("drain_level", 32'(Level), 32'd0);
    endtask

    task automatic sendFrame(input logic [11:0] base, input bit rdy);
        for (int i = 0; i < LENGTH; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'(i), base + 12'(i), rdy);
    endtask

    // 15-sample frame: indices 0..13 then 15, ends naturally.
    task automatic sendShortFrame(input logic [11:0] base, input bit rdy);
        for (int i = 0; i < 14; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'(i), base + 12'(i), rdy);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd15, base + 12'd14, rdy);
    endtask

    task automatic randomCycle(input bit fen, input logic [3:0] add, input int p);
        bit r, en, clr, rdy;
        logic [3:0] a;
        r   = ($urandom_range(0, 299) != 0);
        en  = ($urandom_range(0, 9) != 0);
        clr = ($urandom_range(0, 19) == 0);
        rdy = ($urandom_range(0, 99) < p);
        a   = fen ? add : 4'($urandom);
        applyStimulus(r, en, clr, fen, a, 12'($urandom), rdy);
    endtask

    task automatic runRandom();
        logic [3:0] seq[$];
        int kind, p, n, gap, start;
        for (int f = 0; f < 60; f++) begin
            seq.delete();
            kind = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: p = 100;
                1: p = 70;
                2: p = 30;
                default: p = 0;
            endcase
            if (kind == 1) begin
                for (int i = 0; i < 15; i++) seq.push_back(4'(i));
                n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) seq.push_back(4'($urandom_range(1, 14)));
                seq.push_back(4'd15);
            end else if (kind == 2) begin
                start = $urandom_range(1, 15);
                for (int i = start; i < 16; i++) seq.push_back(4'(i));
            end else begin
                for (int i = 0; i < 16; i++) seq.push_back(4'(i));
            end
            foreach (seq[k]) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) randomCycle(1'b0, 4'd0, p);
                randomCycle(1'b1, seq[k], p);
            end
            gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) randomCycle(1'b0, 4'd0, p);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 1'b1);
        drain();
    endtask

    initial begin
        vec_t vecs[16];
        for (int i = 0; i < 16; i++) begin
            vecs[i].add       = 4'(i);
            vecs[i].data      = 12'(i);
            vecs[i].exp_tdata = 32'(i);
            vecs[i].exp_tlast = (i == 15);
        end

        // Reset
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 1'b0);
        checkOutput("reset_level", 32'(Level), 32'd0);
        checkOutput("reset_overflow", 32'(Overflow), 32'd0);
        checkOutput("reset_framecnt", 32'(FrameCnt), 32'd0);

        // One clean frame with the sink always ready
        $display("[TB] single frame, tready=1");
        beat_log.delete();
        level_max = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, vecs[i].add, vecs[i].data, 1'b1);
            if (i == 0) checkOutput("latency_edge_n", 32'(m_axis_tvalid), 32'd0);
            if (i == 1) checkOutput("latency_edge_n1", 32'(m_axis_tvalid), 32'd1);
        end
        drain();
        checkOutput("t1_beats", 32'(beat_log.size()), 32'd16);
        for (int i = 0; i < 16 && i < beat_log.size(); i++) begin
            checkOutput("t1_tdata", beat_log[i].data, vecs[i].exp_tdata);
            checkOutput("t1_tlast", 32'(beat_log[i].last), 32'(vecs[i].exp_tlast));
        end
        checkOutput("t1_framecnt", 32'(FrameCnt), 32'd1);
        checkOutput("t1_overflow", 32'(Overflow), 32'd0);
        checkOutput("t1_level_max", 32'(level_max <= 2), 32'd1);

        // tready toggling, one sample every two cycles
        $display("[TB] toggling tready, half-rate source");
        beat_log.delete();
        level_max = 0;
        for (int c = 0; c < 32; c++)
            applyStimulus(1'b1, 1'b1, 1'b0, (c % 2 == 0), 4'(c / 2),
                          12'h100 + 12'(c / 2), (c % 2 == 0));
        drain();
        checkOutput("t2_beats", 32'(beat_log.size()), 32'd16);
        for (int i = 0; i < 16 && i < beat_log.size(); i++)
            checkOutput("t2_tdata", beat_log[i].data, 32'h100 + 32'(i));
        checkOutput("t2_level_max", 32'(level_max <= 2), 32'd1);
        checkOutput("t2_framecnt", 32'(FrameCnt), 32'd2);

        // Sink stalled for a 20-sample frame: forced termination at 16 entries
        $display("[TB] stalled sink, forced tlast");
        beat_log.delete();
        for (int k = 0; k < 20; k++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1,
                          (k < 15) ? 4'(k) : ((k < 19) ? 4'(k - 14) : 4'd15),
                          12'h200 + 12'(k), 1'b0);
        checkOutput("t3_level", 32'(Level), 32'd16);
        checkOutput("t3_overflow", 32'(Overflow), 32'd1);
        drain();
        checkOutput("t3_beats", 32'(beat_log.size()), 32'd16);
        if (beat_log.size() == 16) begin
            checkOutput("t3_beat15_last", 32'(beat_log[15].last), 32'd1);
            checkOutput("t3_beat15_data", beat_log[15].data, 32'h20F);
            checkOutput("t3_beat14_last", 32'(beat_log[14].last), 32'd0);
        end
        checkOutput("t3_framecnt", 32'(FrameCnt), 32'd2);
        beat_log.delete();
        sendFrame(12'h300, 1'b1);
        drain();
        checkOutput("t3_next_beats", 32'(beat_log.size()), 32'd16);
        if (beat_log.size() == 16) checkOutput("t3_next_last", 32'(beat_log[15].last), 32'd1);
        checkOutput("t3_next_framecnt", 32'(FrameCnt), 32'd3);

        // Frame start with Level=15: whole frame skipped
        $display("[TB] frame start at Level 15");
        idleCycle(1'b1, 1'b0);
        checkOutput("t4_clr_overflow", 32'(Overflow), 32'd0);
        checkOutput("t4_clr_dropcnt", 32'(DropCnt), 32'd0);
        sendShortFrame(12'h400, 1'b0);
        checkOutput("t4_level15", 32'(Level), 32'd15);
        sendFrame(12'h500, 1'b0);
        checkOutput("t4_level_kept", 32'(Level), 32'd15);
        checkOutput("t4_overflow", 32'(Overflow), 32'd1);
        checkOutput("t4_dropcnt", 32'(DropCnt), DROPCNT_ON ? 32'd16 : 32'd0);
        beat_log.delete();
        drain();
        checkOutput("t4_beats", 32'(beat_log.size()), 32'd15);
        if (beat_log.size() == 15) checkOutput("t4_last_data", beat_log[14].data, 32'h40E);
        checkOutput("t4_framecnt", 32'(FrameCnt), 32'd4);

        // OvfClr coincident with an overflow event
        $display("[TB] OvfClr against a new overflow");
        idleCycle(1'b1, 1'b0);
        checkOutput("t6_overflow_cleared", 32'(Overflow), 32'd0);
        sendShortFrame(12'h600, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 12'h700, 1'b0);
        checkOutput("t6_overflow_wins", 32'(Overflow), 32'd1);
        for (int i = 1; i < 16; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'(i), 12'h700 + 12'(i), 1'b0);
        checkOutput("t6_overflow_sticky", 32'(Overflow), 32'd1);
        idleCycle(1'b1, 1'b0);
        checkOutput("t6_overflow_clear", 32'(Overflow), 32'd0);
        drain();

        // Reset mid-frame at sample 7
        $display("[TB] reset mid-frame");
        for (int i = 0; i < 7; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'(i), 12'h800 + 12'(i), 1'b0);
        checkOutput("t5_level_before", 32'(Level), 32'd7);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 12'h807, 1'b0);
        checkOutput("t5_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("t5_level", 32'(Level), 32'd0);
        beat_log.delete();
        for (int i = 8; i < 16; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'(i), 12'h800 + 12'(i), 1'b1);
        checkOutput("t5_ignored_level", 32'(Level), 32'd0);
        checkOutput("t5_ignored_beats", 32'(beat_log.size()), 32'd0);
        sendFrame(12'h900, 1'b1);
        drain();
        checkOutput("t5_next_beats", 32'(beat_log.size()), 32'd16);
        checkOutput("t5_framecnt", 32'(FrameCnt), 32'd1);

        // Randomized traffic against the model
        $display("[TB] randomized traffic");
        runRandom();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fram_axis_bridge.md
Name: fram_axis_bridge

Overview:
- Downstream stage of Frotaegis_Design. Takes the frame readout stream (FramData/FramAdd/FramEn), which has no backpressure, and buffers it in a FIFO.
- Drives the S2MM AXI-Stream slave with a proper tready/tvalid handshake and tlast framing.
- Drops whole frames or frame tails cleanly on overflow, so the DMA never sees an unterminated packet.

Parameters:
- DATA_SIZE, 12, sample width in bits.
- LENGTH, 32768, samples per frame.
- LENGTH_SIZE, 15, width of FramAdd.
- FIFO_DEPTH, 16, FIFO entries; power of 2, at least 4.
- FIFO_ADD, 4, log2(FIFO_DEPTH).

Ports:
- clk  in  1  single clock for the whole block (clk200 domain at top).
- rstn  in  1  synchronous reset, active-low.
- Enable  in  1  accept new frames when 1; an in-progress frame always completes or terminates.
- OvfClr  in  1  one-cycle pulse that clears Overflow.
- FramData  in  DATA_SIZE  sample.
- FramAdd  in  LENGTH_SIZE  sample index within the frame.
- FramEn  in  1  sample strobe.
- m_axis_tdata  out  32  zero-extended FramData.
- m_axis_tkeep  out  4  constant 4'hF.
- m_axis_tlast  out  1  last beat of a packet.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- Overflow  out  1  sticky flag: a sample was discarded.
- FrameCnt  out  16  count of packets transferred with a natural (non-forced) tlast; wraps.
- Level  out  FIFO_ADD+1  current FIFO occupancy.
- DropCnt  out  16  number of discarded samples (see Optional Feature).

Behaviour:
- Reset, while rstn=0 on a rising edge:
  - state=IDLE, FIFO empty, Level=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - Overflow=0, FrameCnt=0, DropCnt=0.
- FIFO entry format: {last, data}. Write occurs only while count<FIFO_DEPTH.
- Reset mid-frame empties the FIFO immediately and returns to IDLE.
- FSM states: IDLE, PASS, DROP.
- IDLE:
  - FramEn & FramAdd==0 & Enable & count<FIFO_DEPTH-1 → write the sample (last=0); go to PASS.
  - FramEn & FramAdd==0 with Enable=1 but count>=FIFO_DEPTH-1 → discard the sample; Overflow=1; go to DROP.
  - All other FramEn samples are ignored; Overflow is not set for them.
- PASS, on every FramEn:
  - FramAdd==LENGTH-1 → write with last=1; go to IDLE.
  - Otherwise, if count==FIFO_DEPTH-1 → write with last=1 (forced termination); Overflow=1; go to DROP.
  - Otherwise → write with last=0.
  - The last FIFO slot is always reserved for a terminator.
- DROP:
  - Discard every FramEn sample.
  - On FramEn & FramAdd==LENGTH-1 → go to IDLE.
- Output side: FWFT FIFO with a registered output stage.
  - A beat transfers when m_axis_tvalid & m_axis_tready.
  - tdata, tlast and tvalid hold stable while tvalid=1 and tready=0.
  - Latency: a sample written into an empty FIFO at edge N appears with tvalid=1 after edge N+1.
  - Full throughput is 1 beat/cycle while tready=1.
- Simultaneous read and write in one cycle leaves count unchanged. The full/empty decision uses count before the edge.
- FrameCnt increments when a beat transfers with tlast=1 and that entry was written on FramAdd==LENGTH-1.
  - The FIFO carries a hidden "natural" bit for this purpose.
- OvfClr coincident with a new overflow: the new overflow wins, Overflow stays 1.
- Enable dropping to 0 mid-frame: the PASS frame still completes normally.
- FramAdd jumps are not checked. Framing relies only on FramAdd==0 and FramAdd==LENGTH-1.

Optional Feature:
- Macro: FRAM_AXIS_DROPCNT_EN.
- Defined: DropCnt is a 16-bit saturating counter. It increments on every sample discarded in DROP, and on the frame-start sample rejected for a full FIFO in IDLE. It clears on OvfClr.
- Undefined: DropCnt is tied to 0 and the counter logic is removed.

Decomposition:
- Package frotaegis_pkg holds:
  - the state enum (IDLE/PASS/DROP);
  - AXIS_WIDTH=32 and AXIS_KEEP=4'hF;
  - the FIFO entry field offsets (last, natural).
- Natural sub-module: frotaegis_sync_fifo.
  - Parameterised width/depth, FWFT, with count output.
  - Instantiated once with width DATA_SIZE+2.

Test Plan:
- tready=1, Enable=1, one frame with LENGTH=16 (bench override) → 16 beats with tdata=0x000..0x00F, tlast only on beat 16, FrameCnt=1, Overflow=0.
- tready toggled 1/0 each cycle with source at 1 sample per 2 cycles → no loss, tdata stable whenever tvalid&!tready, Level never exceeds 2.
- tready=0 for a whole frame, FIFO_DEPTH=16 → exactly 16 entries stored, 16th beat has tlast=1 (forced), Overflow=1, FrameCnt unchanged; next frame after tready=1 arrives intact.
- Frame start arriving while Level=15 → whole frame skipped, Overflow=1, DropCnt=16 with FRAM_AXIS_DROPCNT_EN (LENGTH=16).
- rstn=0 asserted mid-frame at sample 7 → next edge has tvalid=0 and Level=0; samples until the next FramAdd==0 are ignored.
- OvfClr pulse on the same cycle as an overflow event → Overflow remains 1; a later OvfClr alone → Overflow=0.
